// File: rtl/trace_pkg.sv
// Shared types for the trace stimulus player.
//   - Def* localparams: default build configuration of the player.
//   - IDX_W:            trace index width for the default depth.
//   - state_e:          replay FSM states.
//   - trace_entry_t:    one stored event (delay, channel mask, packed channel data) in the
//                       default configuration.
package trace_pkg;

  localparam int unsigned DefNumInputs  = 1;
  localparam int unsigned DefDataWidth  = 64;
  localparam int unsigned DefDepth      = 16;
  localparam int unsigned DefDelayWidth = 16;
  localparam int unsigned DefCntWidth   = 32;

  localparam int unsigned IDX_W = $clog2(DefDepth);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StFire = 2'd2,
    StDone = 2'd3
  } state_e;

  typedef struct packed {
    logic [DefDelayWidth-1:0]             delay;
    logic [DefNumInputs-1:0]              mask;
    logic [DefNumInputs*DefDataWidth-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/trace_mem.sv
// Trace storage: Depth entries of {delay, mask, data}.
//   clk_i             clock
//   we_i              write strobe (already qualified by the caller)
//   waddr_i           write index
//   wdelay_i/wmask_i/wdata_i  entry fields to store
//   raddr_i           read index
//   rdelay_o/rmask_o/rdata_o  entry fields at raddr_i, combinational
// Synchronous write, combinational read, deliberately no reset so the trace survives rst.
module trace_mem #(
  parameter int unsigned Depth      = 16,
  parameter int unsigned DelayWidth = 16,
  parameter int unsigned NumInputs  = 1,
  parameter int unsigned DataWidth  = 64
) (
  input  logic                           clk_i,
  input  logic                           we_i,
  input  logic [$clog2(Depth)-1:0]       waddr_i,
  input  logic [DelayWidth-1:0]          wdelay_i,
  input  logic [NumInputs-1:0]           wmask_i,
  input  logic [NumInputs*DataWidth-1:0] wdata_i,
  input  logic [$clog2(Depth)-1:0]       raddr_i,
  output logic [DelayWidth-1:0]          rdelay_o,
  output logic [NumInputs-1:0]           rmask_o,
  output logic [NumInputs*DataWidth-1:0] rdata_o
);

  logic [DelayWidth-1:0]          delay_mem [Depth];
  logic [NumInputs-1:0]           mask_mem  [Depth];
  logic [NumInputs*DataWidth-1:0] data_mem  [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      delay_mem[waddr_i] <= wdelay_i;
      mask_mem[waddr_i]  <= wmask_i;
      data_mem[waddr_i]  <= wdata_i;
    end
  end

  assign rdelay_o = delay_mem[raddr_i];
  assign rmask_o  = mask_mem[raddr_i];
  assign rdata_o  = data_mem[raddr_i];

endmodule

// File: rtl/trace_stimulus_player.sv
// Replays a stored trace of timestamped input events into a monitor's input ports.
//   clk, rst (sync, active-high), en (global stall when 0)
//   wr_en/wr_addr/wr_delay/wr_mask/wr_data  trace load port, accepted only while idle
//   num_events/start/loop/stop              replay control
//   input_data/new_input                    monitor-side stimulus (registered)
//   busy/done/wr_err/event_idx/fired_count  status
// Event k fires delay[k] + 2 cycles after its predecessor (or after start for k = 0).
module trace_stimulus_player
  import trace_pkg::*;
#(
  parameter int unsigned NUM_INPUTS  = DefNumInputs,
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned DEPTH       = DefDepth,
  parameter int unsigned DELAY_WIDTH = DefDelayWidth,
  parameter int unsigned CNT_WIDTH   = DefCntWidth
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             wr_en,
  input  logic [$clog2(DEPTH)-1:0]         wr_addr,
  input  logic [DELAY_WIDTH-1:0]           wr_delay,
  input  logic [NUM_INPUTS-1:0]            wr_mask,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] wr_data,
  input  logic [$clog2(DEPTH):0]           num_events,
  input  logic                             start,
  input  logic                             loop,
  input  logic                             stop,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] input_data,
  output logic [NUM_INPUTS-1:0]            new_input,
  output logic                             busy,
  output logic                             done,
  output logic                             wr_err,
  output logic [$clog2(DEPTH)-1:0]         event_idx,
  output logic [CNT_WIDTH-1:0]             fired_count
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned LenW = IdxW + 1;
  localparam logic [LenW-1:0] DepthLen = LenW'(DEPTH);

  state_e                          state_q, state_d;
  logic [DELAY_WIDTH-1:0]          cnt_q, cnt_d;
  logic [IdxW-1:0]                 idx_q, idx_d;
  logic [LenW-1:0]                 len_q, len_d;
  logic                            loop_q, loop_d;
  logic [CNT_WIDTH-1:0]            fired_q, fired_d;
  logic [NUM_INPUTS-1:0]           new_input_q, new_input_d;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] input_data_q, input_data_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;
  logic                            wr_err_q, wr_err_d;

  logic [IdxW-1:0]                  rd_addr;
  logic [DELAY_WIDTH-1:0]           rd_delay;
  logic [NUM_INPUTS-1:0]            rd_mask;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] rd_data;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] masked_data;
  logic [IdxW-1:0]                  idx_inc;
  logic                             is_last;
  logic                             mem_we;

  assign mem_we  = wr_en && (state_q == StIdle);
  assign idx_inc = idx_q + IdxW'(1);
  assign is_last = ({1'b0, idx_q} == (len_q - LenW'(1)));

  // Single read port: entry 0 while idle (start loads delay[0]), the pending event while
  // waiting, and the successor (or entry 0 on wrap) while firing.
  always_comb begin
    rd_addr = idx_q;
    unique case (state_q)
      StIdle:  rd_addr = '0;
      StFire:  rd_addr = is_last ? '0 : idx_inc;
      default: rd_addr = idx_q;
    endcase
  end

  trace_mem #(
    .Depth      (DEPTH),
    .DelayWidth (DELAY_WIDTH),
    .NumInputs  (NUM_INPUTS),
    .DataWidth  (DATA_WIDTH)
  ) u_trace_mem (
    .clk_i    (clk),
    .we_i     (mem_we),
    .waddr_i  (wr_addr),
    .wdelay_i (wr_delay),
    .wmask_i  (wr_mask),
    .wdata_i  (wr_data),
    .raddr_i  (rd_addr),
    .rdelay_o (rd_delay),
    .rmask_o  (rd_mask),
    .rdata_o  (rd_data)
  );

  // Unmasked channels are driven as zero.
  always_comb begin
    masked_data = '0;
    for (int k = 0; k < int'(NUM_INPUTS); k++) begin
      if (rd_mask[k]) begin
        masked_data[k*DATA_WIDTH +: DATA_WIDTH] = rd_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    len_d        = len_q;
    loop_d       = loop_q;
    fired_d      = fired_q;
    new_input_d  = '0;
    input_data_d = '0;
    done_d       = 1'b0;
    wr_err_d     = wr_en && (state_q != StIdle);

    if (en) begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            fired_d = '0;
            idx_d   = '0;
            if (num_events == '0) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              len_d   = (num_events > DepthLen) ? DepthLen : num_events;
              loop_d  = loop;
              cnt_d   = rd_delay;
              state_d = StWait;
            end
          end
        end
        StWait: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DELAY_WIDTH'(1);
          end else begin
            // Pulse is registered on entry so it is visible during the FIRE cycle.
            state_d      = StFire;
            new_input_d  = rd_mask;
            input_data_d = masked_data;
          end
        end
        StFire: begin
          fired_d = (&fired_q) ? fired_q : fired_q + CNT_WIDTH'(1);
          if (!is_last) begin
            idx_d   = idx_inc;
            cnt_d   = rd_delay;
            state_d = StWait;
          end else if (loop_q) begin
            idx_d   = '0;
            cnt_d   = rd_delay;
            state_d = StWait;
          end else begin
            idx_d   = idx_inc;
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase

      // Abort wins over any pending fire or completion.
      if (stop && (state_q != StIdle)) begin
        state_d      = StIdle;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        fired_d      = fired_q;
        new_input_d  = '0;
        input_data_d = '0;
        done_d       = 1'b0;
      end
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      idx_q        <= '0;
      len_q        <= '0;
      loop_q       <= 1'b0;
      fired_q      <= '0;
      new_input_q  <= '0;
      input_data_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      loop_q       <= loop_d;
      fired_q      <= fired_d;
      new_input_q  <= new_input_d;
      input_data_q <= input_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      wr_err_q     <= wr_err_d;
    end
  end

  assign input_data  = input_data_q;
  assign new_input   = new_input_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign wr_err      = wr_err_q;
  assign event_idx   = idx_q;
  assign fired_count = fired_q;

endmodule

// File: tb/tb_trace_stimulus_player.sv
// Directed bench for trace_stimulus_player (2 channels, 64-bit data, depth 16).
// Expected pulses/done are queued with their cycle when a replay is started and a negedge
// monitor pops and compares each one as the DUT produces it.
module tb_trace_stimulus_player;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b1;
  logic         wr_en = 1'b0;
  logic [3:0]   wr_addr = '0;
  logic [15:0]  wr_delay = '0;
  logic [1:0]   wr_mask = '0;
  logic [127:0] wr_data = '0;
  logic [4:0]   num_events = '0;
  logic         start = 1'b0;
  logic         loop = 1'b0;
  logic         stop = 1'b0;
  logic [127:0] input_data;
  logic [1:0]   new_input;
  logic         busy;
  logic         done;
  logic         wr_err;
  logic [3:0]   event_idx;
  logic [31:0]  fired_count;

  trace_stimulus_player #(
    .NUM_INPUTS  (2),
    .DATA_WIDTH  (64),
    .DEPTH       (16),
    .DELAY_WIDTH (16),
    .CNT_WIDTH   (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_delay    (wr_delay),
    .wr_mask     (wr_mask),
    .wr_data     (wr_data),
    .num_events  (num_events),
    .start       (start),
    .loop        (loop),
    .stop        (stop),
    .input_data  (input_data),
    .new_input   (new_input),
    .busy        (busy),
    .done        (done),
    .wr_err      (wr_err),
    .event_idx   (event_idx),
    .fired_count (fired_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string        tag;
    int           cyc;
    logic [1:0]   mask;
    logic [127:0] data;
    logic         done;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  task automatic push_pulse(input string tag, input int c, input logic [1:0] m,
                            input logic [127:0] d);
    exp_t e;
    e.tag = tag; e.cyc = c; e.mask = m; e.data = d; e.done = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input string tag, input int c);
    exp_t e;
    e.tag = tag; e.cyc = c; e.mask = 2'b00; e.data = '0; e.done = 1'b1;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: any pulse or done must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && (new_input !== 2'b00 || done !== 1'b0)) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $error("FAIL unexpected_output cyc=%0d observed ni=%b done=%b expected none",
               cyc, new_input, done);
      end else begin
        cur = exp_q.pop_front();
        assert (cyc == cur.cyc && new_input === cur.mask && input_data === cur.data &&
                done === cur.done)
        else begin
          n_err++;
          $error("FAIL %s observed cyc=%0d ni=%b data=%h done=%b expected cyc=%0d ni=%b data=%h done=%b",
                 cur.tag, cyc, new_input, input_data, done, cur.cyc, cur.mask, cur.data,
                 cur.done);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the drive point (#1 after posedge) of cycle c.
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int a, input int d, input logic [1:0] m, input logic [63:0] v0,
                    input logic [63:0] v1);
    wr_en = 1'b1; wr_addr = 4'(a); wr_delay = 16'(d); wr_mask = m; wr_data = {v1, v0};
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic start_replay(input int n, input logic lp, output int s);
    s = cyc;
    start = 1'b1; num_events = 5'(n); loop = lp;
    @(posedge clk);
    #1;
    start = 1'b0; loop = 1'b0;
  endtask

  int s;

  initial begin
    // Reset state
    goto(3);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_new_input", new_input, 0);
    check("rst_input_data", input_data, 0);
    check("rst_fired", fired_count, 0);
    check("rst_event_idx", event_idx, 0);
    check("rst_wr_err", wr_err, 0);
    goto(4);
    rst = 1'b0;

    // Test 1: delays 10,3,0 with values 1,2,3 on channel 0
    wr(0, 10, 2'b01, 64'd1, 64'd0);
    wr(1, 3, 2'b01, 64'd2, 64'd0);
    wr(2, 0, 2'b01, 64'd3, 64'd0);
    check("t1_wr_err_idle", wr_err, 0);
    start_replay(3, 1'b0, s);
    push_pulse("t1_ev0", s + 12, 2'b01, 128'd1);
    push_pulse("t1_ev1", s + 17, 2'b01, 128'd2);
    push_pulse("t1_ev2", s + 19, 2'b01, 128'd3);
    push_done("t1_done", s + 20);
    @(negedge clk);
    check("t1_busy", busy, 1);
    goto(s + 24);
    @(negedge clk);
    check("t1_fired", fired_count, 3);
    check("t1_idle", busy, 0);
    check("t1_pending", exp_q.size(), 0);

    // Test 2: channel masks 01 then 11
    wr(0, 2, 2'b01, 64'hA0A0_0000_0000_00A0, 64'hA1A1_0000_0000_00A1);
    wr(1, 1, 2'b11, 64'hB0B0_0000_0000_00B0, 64'hB1B1_0000_0000_00B1);
    start_replay(2, 1'b0, s);
    push_pulse("t2_ch0_only", s + 4, 2'b01, {64'h0, 64'hA0A0_0000_0000_00A0});
    push_pulse("t2_both", s + 7, 2'b11,
               {64'hB1B1_0000_0000_00B1, 64'hB0B0_0000_0000_00B0});
    push_done("t2_done", s + 8);
    goto(s + 12);
    @(negedge clk);
    check("t2_fired", fired_count, 2);
    check("t2_pending", exp_q.size(), 0);

    // Test 3: loop of two delay-1 events, then stop mid-WAIT
    wr(0, 1, 2'b01, 64'h11, 64'h0);
    wr(1, 1, 2'b10, 64'h0, 64'h22);
    start_replay(2, 1'b1, s);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) push_pulse("t3_ev0", s + 3 + 3 * i, 2'b01, 128'h11);
      else push_pulse("t3_ev1", s + 3 + 3 * i, 2'b10, {64'h22, 64'h0});
    end
    goto(s + 4);
    @(negedge clk);
    check("t3_idx_after_ev0", event_idx, 1);
    goto(s + 7);
    @(negedge clk);
    check("t3_idx_wrap", event_idx, 0);
    goto(s + 13);
    stop = 1'b1;
    @(negedge clk);
    check("t3_fired_pre_stop", fired_count, 4);
    goto(s + 14);
    stop = 1'b0;
    @(negedge clk);
    check("t3_stop_busy", busy, 0);
    check("t3_stop_fired_hold", fired_count, 4);
    goto(s + 22);
    check("t3_pending", exp_q.size(), 0);

    // Test 4: en low for 4 cycles exactly when the fire is due
    wr(0, 3, 2'b01, 64'hE0, 64'h0);
    start_replay(1, 1'b0, s);
    push_pulse("t4_deferred", s + 9, 2'b01, 128'hE0);
    push_done("t4_done", s + 10);
    goto(s + 4);
    en = 1'b0;
    goto(s + 8);
    en = 1'b1;
    goto(s + 13);
    @(negedge clk);
    check("t4_fired", fired_count, 1);
    check("t4_pending", exp_q.size(), 0);

    // Test 5: write while busy is rejected and flagged
    wr(0, 2, 2'b01, 64'hF0, 64'h0);
    wr(1, 0, 2'b01, 64'hF1, 64'h0);
    start_replay(2, 1'b0, s);
    push_pulse("t5_ev0", s + 4, 2'b01, 128'hF0);
    push_pulse("t5_ev1", s + 6, 2'b01, 128'hF1);
    push_done("t5_done", s + 7);
    goto(s + 1);
    wr_en = 1'b1; wr_addr = 4'd0; wr_delay = 16'd5; wr_mask = 2'b11; wr_data = '1;
    @(negedge clk);
    check("t5_wr_err_before", wr_err, 0);
    goto(s + 2);
    wr_en = 1'b0;
    @(negedge clk);
    check("t5_wr_err_pulse", wr_err, 1);
    goto(s + 3);
    @(negedge clk);
    check("t5_wr_err_clear", wr_err, 0);
    goto(s + 10);
    check("t5_pending", exp_q.size(), 0);
    start_replay(2, 1'b0, s);
    push_pulse("t5_replay_ev0", s + 4, 2'b01, 128'hF0);
    push_pulse("t5_replay_ev1", s + 6, 2'b01, 128'hF1);
    push_done("t5_replay_done", s + 7);
    goto(s + 10);
    check("t5_replay_pending", exp_q.size(), 0);

    // Test 6: num_events = 0 completes immediately
    start_replay(0, 1'b0, s);
    push_done("t6_done", s + 1);
    goto(s + 4);
    @(negedge clk);
    check("t6_fired", fired_count, 0);
    check("t6_pending", exp_q.size(), 0);

    // Test 7: reset mid-WAIT, then replay the retained trace
    start_replay(2, 1'b0, s);
    goto(s + 2);
    rst = 1'b1;
    goto(s + 3);
    @(negedge clk);
    check("t7_rst_busy", busy, 0);
    check("t7_rst_new_input", new_input, 0);
    check("t7_rst_input_data", input_data, 0);
    check("t7_rst_idx", event_idx, 0);
    check("t7_rst_fired", fired_count, 0);
    goto(s + 4);
    rst = 1'b0;
    goto(s + 5);
    start_replay(2, 1'b0, s);
    push_pulse("t7_retained_ev0", s + 4, 2'b01, 128'hF0);
    push_pulse("t7_retained_ev1", s + 6, 2'b01, 128'hF1);
    push_done("t7_retained_done", s + 7);
    goto(s + 10);
    @(negedge clk);
    check("t7_fired", fired_count, 2);
    check("t7_pending", exp_q.size(), 0);

    // Test 8: num_events above DEPTH is clamped to 16
    for (int i = 0; i < 16; i++) wr(i, 0, 2'b01, 64'(100 + i), 64'h0);
    start_replay(20, 1'b0, s);
    for (int i = 0; i < 16; i++) push_pulse("t8_clamp_ev", s + 2 + 2 * i, 2'b01, 128'(100 + i));
    push_done("t8_done", s + 33);
    goto(s + 37);
    @(negedge clk);
    check("t8_fired", fired_count, 16);
    check("t8_pending", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
